// File: rtl/servant_uart_rx.sv
// UART receiver with a byte FIFO, sticky error flags and a registered data-pending irq.
// Define SERVANT_UART_RX_PARITY_EN to build the 8E1 variant; the default build is 8N1.
module servant_uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 556,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic       wb_clk,
   input  logic       wb_rst,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_vld,
   input  logic       i_rdy,
   output logic       o_irq,
   output logic       o_frame_err,
   output logic       o_overrun,
   output logic       o_parity_err,
   input  logic       i_clr
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;

   state_t         state;
   logic           rx_meta;
   logic           rxs;
   logic [CW-1:0]  cnt;
   logic [2:0]     bit_idx;
   logic [7:0]     shift;
   logic           push_q;
   logic [7:0]     push_data;
   logic           perr;
   logic           cnt_zero;

   assign cnt_zero = (cnt == CW'(0));

`ifdef SERVANT_UART_RX_PARITY_EN
   logic par_q;
   assign perr = (^shift) ^ par_q;
`else
   assign perr = 1'b0;
   assign o_parity_err = 1'b0;
`endif

   // Synchroniser, frame FSM and receive-side sticky flags
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         rx_meta     <= 1'b1;
         rxs         <= 1'b1;
         state       <= S_IDLE;
         cnt         <= CW'(0);
         bit_idx     <= 3'd0;
         shift       <= 8'd0;
         push_q      <= 1'b0;
         push_data   <= 8'd0;
         o_frame_err <= 1'b0;
`ifdef SERVANT_UART_RX_PARITY_EN
         par_q        <= 1'b0;
         o_parity_err <= 1'b0;
`endif
      end else begin
         rx_meta <= i_rx;
         rxs     <= rx_meta;
         push_q  <= 1'b0;
         if (i_clr) begin
            o_frame_err <= 1'b0;
`ifdef SERVANT_UART_RX_PARITY_EN
            o_parity_err <= 1'b0;
`endif
         end
         if (!cnt_zero) cnt <= cnt - CW'(1);
         case (state)
            S_IDLE: begin
               if (!rxs) begin
                  cnt   <= CNT_HALF;
                  state <= S_START;
               end
            end
            S_START: begin
               if (cnt_zero) begin
                  if (rxs) begin
                     state <= S_IDLE;
                  end else begin
                     cnt     <= CNT_FULL;
                     bit_idx <= 3'd0;
                     state   <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (cnt_zero) begin
                  shift   <= {rxs, shift[7:1]};
                  cnt     <= CNT_FULL;
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef SERVANT_UART_RX_PARITY_EN
                     state <= S_PARITY;
`else
                     state <= S_STOP;
`endif
                  end
               end
            end
`ifdef SERVANT_UART_RX_PARITY_EN
            S_PARITY: begin
               if (cnt_zero) begin
                  par_q <= rxs;
                  cnt   <= CNT_FULL;
                  state <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               if (cnt_zero) begin
                  if (rxs) begin
                     state <= S_IDLE;
                     if (perr) begin
`ifdef SERVANT_UART_RX_PARITY_EN
                        o_parity_err <= 1'b1;
`endif
                     end else begin
                        push_q    <= 1'b1;
                        push_data <= shift;
                     end
                  end else begin
                     o_frame_err <= 1'b1;
                     state       <= S_BREAK;
                  end
               end
            end
            S_BREAK: begin
               if (rxs) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_nxt;
   logic [PW-1:0] rd_nxt;
   logic          full;
   logic          do_push;
   logic          do_pop;

   assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign do_pop  = o_vld & i_rdy;
   assign do_push = push_q & (~full | do_pop);
   assign wr_nxt  = wr_ptr + PW'(do_push);
   assign rd_nxt  = rd_ptr + PW'(do_pop);

   always_ff @(posedge wb_clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   // FIFO pointers and registered head; a push into an empty slot forwards its byte
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         wr_ptr    <= PW'(0);
         rd_ptr    <= PW'(0);
         o_vld     <= 1'b0;
         o_data    <= 8'd0;
         o_irq     <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         wr_ptr <= wr_nxt;
         rd_ptr <= rd_nxt;
         o_vld  <= (wr_nxt != rd_nxt);
         o_data <= (do_push && (rd_nxt == wr_ptr)) ? push_data : mem[rd_nxt[AW-1:0]];
         o_irq  <= o_vld;
         if (i_clr) o_overrun <= 1'b0;
         if (push_q && full && !do_pop) o_overrun <= 1'b1;
      end
   end

endmodule
